// File: rtl/fp_stim_gen.sv
// Floating-point operand sequencer: emits num_vectors (a, b, operation_select) vectors for an FP add/sub datapath.
// Latency: out_valid rises 2 cycles after start is accepted; at most one vector every 2 cycles.
// Backpressure: a vector is held stable until out_valid & out_ready; start is ignored while busy.
//
// Ports: clk/rst_n (async active-low); start + mode_a/mode_b/op_mode/order/num_vectors/fixed_a/fixed_b
// configuration (latched on start); a/b/operation_select/out_valid/out_ready vector handshake;
// vec_idx, busy and done run status.
module fp_stim_gen #(
    parameter int               WIDTH     = 32,
    parameter int               EXP_BITS  = 8,
    parameter int               MANT_BITS = 23,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 32'h8020_0003,
    parameter logic [WIDTH-1:0] SEED      = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       mode_a,
    input  logic [3:0]       mode_b,
    input  logic [1:0]       op_mode,
    input  logic [1:0]       order,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [WIDTH-1:0] fixed_a,
    input  logic [WIDTH-1:0] fixed_b,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             operation_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] vec_idx,
    output logic             busy,
    output logic             done
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [WIDTH-1:0] LFSR_INIT =
        (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [3:0]       cfg_mode_a;
    logic [3:0]       cfg_mode_b;
    logic [1:0]       cfg_op;
    logic [1:0]       cfg_order;
    logic [CNT_W-1:0] cfg_num;
    logic [WIDTH-1:0] cfg_fixed_a;
    logic [WIDTH-1:0] cfg_fixed_b;
    logic [WIDTH-1:0] lfsr;

    logic [WIDTH-1:0] r1, r2;
    logic [WIDTH-1:0] cls_a, cls_b;
    logic [WIDTH-1:0] a_nxt, b_nxt;
    logic             op_nxt;
    logic             last_vec;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    // Operand class encoder; every field is assembled from EXP_BITS/MANT_BITS so
    // non-binary32 formats get the right special values.
    function automatic logic [WIDTH-1:0] class_val(input logic [3:0]       mode,
                                                   input logic [WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0] fixed_v);
        logic                 sgn;
        logic [EXP_BITS-1:0]  ex;
        logic [MANT_BITS-1:0] mt;
        logic [WIDTH-1:0]     res;
        sgn = 1'b0;
        ex  = '0;
        mt  = '0;
        res = '0;
        case (mode)
            4'd1: res = r;
            4'd2: begin
                ex = '1;
                mt[MANT_BITS-1] = 1'b1;
                res = {sgn, ex, mt};
            end
            4'd3, 4'd4: begin
                sgn = (mode == 4'd4);
                ex  = '1;
                res = {sgn, ex, mt};
            end
            4'd5, 4'd6: begin
                sgn   = (mode == 4'd6);
                ex    = '1;
                ex[0] = 1'b0;
                mt    = '1;
                res   = {sgn, ex, mt};
            end
            4'd7, 4'd8: begin
                sgn   = (mode == 4'd8);
                ex[0] = 1'b1;
                res   = {sgn, ex, mt};
            end
            4'd9, 4'd10: begin
                sgn   = (mode == 4'd10);
                mt[0] = 1'b1;
                res   = {sgn, ex, mt};
            end
            4'd11: begin
                // Exponent just above bias with a small random offset, three random
                // mantissa MSBs: values land in a narrow positive range.
                ex[EXP_BITS-1]            = 1'b1;
                ex[1:0]                   = r[1:0];
                mt[MANT_BITS-1 -: 3]      = r[4:2];
                res = {sgn, ex, mt};
            end
            4'd12:   res = fixed_v;
            default: res = '0;
        endcase
        return res;
    endfunction

    always_comb begin
        r1     = lfsr_step(lfsr);
        r2     = lfsr_step(r1);
        cls_a  = class_val(cfg_mode_a, r1, cfg_fixed_a);
        cls_b  = class_val(cfg_mode_b, r2, cfg_fixed_b);
        a_nxt  = cls_a;
        b_nxt  = cls_b;
        if ((cfg_order == 2'd1 && cls_a < cls_b) ||
            (cfg_order == 2'd2 && cls_a > cls_b)) begin
            a_nxt = cls_b;
            b_nxt = cls_a;
        end
        case (cfg_op)
            2'd0:    op_nxt = 1'b0;
            2'd1:    op_nxt = 1'b1;
            default: op_nxt = r1[0] ^ r2[WIDTH-1];
        endcase
    end

    assign last_vec = (vec_idx == cfg_num - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_vectors != '0) ? S_GEN : S_DONE;
                end
            end
            S_GEN:     state_nxt = S_PRESENT;
            S_PRESENT: begin
                if (out_ready) begin
                    state_nxt = last_vec ? S_DONE : S_GEN;
                end
            end
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a                <= '0;
            b                <= '0;
            operation_select <= 1'b0;
            out_valid        <= 1'b0;
            vec_idx          <= '0;
            busy             <= 1'b0;
            lfsr             <= LFSR_INIT;
            cfg_mode_a       <= '0;
            cfg_mode_b       <= '0;
            cfg_op           <= '0;
            cfg_order        <= '0;
            cfg_num          <= '0;
            cfg_fixed_a      <= '0;
            cfg_fixed_b      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_mode_a  <= mode_a;
                        cfg_mode_b  <= mode_b;
                        cfg_op      <= op_mode;
                        cfg_order   <= order;
                        cfg_num     <= num_vectors;
                        cfg_fixed_a <= fixed_a;
                        cfg_fixed_b <= fixed_b;
                        busy        <= 1'b1;
                        vec_idx     <= '0;
                    end
                end
                S_GEN: begin
                    // LFSR advances every GEN even if neither operand is random.
                    lfsr             <= r2;
                    a                <= a_nxt;
                    b                <= b_nxt;
                    operation_select <= op_nxt;
                    out_valid        <= 1'b1;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Holding vec_idx on the last vector keeps it from wrapping
                        // when num_vectors is the counter maximum.
                        if (!last_vec) begin
                            vec_idx <= vec_idx + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_stim_gen.sv
// Directed bench for fp_stim_gen with default parameters (binary32, SEED=1).
// Each check is an immediate assertion; failures are counted and reported.
// Ends with one summary line.
module tb_fp_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  mode_a, mode_b;
    logic [1:0]  op_mode, order;
    logic [15:0] num_vectors;
    logic [31:0] fixed_a, fixed_b;
    logic [31:0] a, b;
    logic        operation_select;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] vec_idx;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    fp_stim_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .mode_a           (mode_a),
        .mode_b           (mode_b),
        .op_mode          (op_mode),
        .order            (order),
        .num_vectors      (num_vectors),
        .fixed_a          (fixed_a),
        .fixed_b          (fixed_b),
        .a                (a),
        .b                (b),
        .operation_select (operation_select),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .vec_idx          (vec_idx),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        out_ready   = 1'b0;
        mode_a      = 4'd0;
        mode_b      = 4'd0;
        op_mode     = 2'd0;
        order       = 2'd0;
        num_vectors = 16'd0;
        fixed_a     = 32'h0;
        fixed_b     = 32'h0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int c;
        c = 0;
        while (out_valid !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        chk(tag, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic run_single(input logic [1:0] ord);
        mode_a      = 4'd1;
        mode_b      = 4'd1;
        op_mode     = 2'd0;
        order       = ord;
        num_vectors = 16'd1;
        out_ready   = 1'b1;
        pulse_start();
        chk("t1_valid_at_start+1", {31'b0, out_valid}, 32'd0);
        chk("t1_busy_after_start", {31'b0, busy}, 32'd1);
        tick();
        chk("t1_valid_at_start+2", {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        logic [31:0] m, r1, r2;
        int nvec;

        // ---- reset state ----
        rst_n = 1'b0;
        start = 1'b0; out_ready = 1'b0; mode_a = 4'd0; mode_b = 4'd0;
        op_mode = 2'd0; order = 2'd0; num_vectors = 16'd0;
        fixed_a = 32'h0; fixed_b = 32'h0;
        #12;
        chk("rst_a", a, 32'h0);
        chk("rst_b", b, 32'h0);
        chk("rst_op", {31'b0, operation_select}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_vec_idx", {16'b0, vec_idx}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- test 1: random operands, add, single vector ----
        run_single(2'd0);
        chk("t1_a", a, 32'h8020_0003);
        chk("t1_b", b, 32'hC030_0002);
        chk("t1_op", {31'b0, operation_select}, 32'd0);
        chk("t1_vec_idx", {16'b0, vec_idx}, 32'd0);
        chk("t1_done_before_hs", {31'b0, done}, 32'd0);
        tick();
        chk("t1_done_pulse", {31'b0, done}, 32'd1);
        chk("t1_valid_dropped", {31'b0, out_valid}, 32'd0);
        tick();
        chk("t1_done_cleared", {31'b0, done}, 32'd0);
        chk("t1_busy_cleared", {31'b0, busy}, 32'd0);
        chk("t1_a_held", a, 32'h8020_0003);

        // ---- test 2: QNAN / -inf, sub, three vectors ----
        mode_a = 4'd2; mode_b = 4'd4; op_mode = 2'd1; order = 2'd0;
        num_vectors = 16'd3; out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            wait_vld("t2_valid");
            chk("t2_a", a, 32'h7FC0_0000);
            chk("t2_b", b, 32'hFF80_0000);
            chk("t2_op", {31'b0, operation_select}, 32'd1);
            chk("t2_vec_idx", {16'b0, vec_idx}, i);
            tick();
            chk("t2_done", {31'b0, done}, (i == 2) ? 32'd1 : 32'd0);
        end
        tick();
        chk("t2_done_single", {31'b0, done}, 32'd0);

        // ---- test 3: ordering ----
        do_reset();
        run_single(2'd2);
        chk("t3_le_a", a, 32'h8020_0003);
        chk("t3_le_b", b, 32'hC030_0002);
        tick(); tick();
        do_reset();
        run_single(2'd1);
        chk("t3_ge_a", a, 32'hC030_0002);
        chk("t3_ge_b", b, 32'h8020_0003);
        tick(); tick();

        // ---- test 4: CUSTOM / min denormal, backpressure ----
        do_reset();
        mode_a = 4'd11; mode_b = 4'd9; op_mode = 2'd0; order = 2'd0;
        num_vectors = 16'd1; out_ready = 1'b0;
        pulse_start();
        wait_vld("t4_valid");
        for (int i = 0; i < 5; i++) begin
            chk("t4_a_stable", a, 32'h4180_0000);
            chk("t4_b_stable", b, 32'h0000_0001);
            chk("t4_valid_held", {31'b0, out_valid}, 32'd1);
            chk("t4_vec_idx", {16'b0, vec_idx}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t4_done", {31'b0, done}, 32'd1);
        tick();

        // ---- test 5: zero-length run, start while busy ----
        num_vectors = 16'd0;
        pulse_start();
        chk("t5_zero_done", {31'b0, done}, 32'd1);
        chk("t5_zero_no_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("t5_zero_done_clr", {31'b0, done}, 32'd0);
        chk("t5_zero_still_no_valid", {31'b0, out_valid}, 32'd0);

        mode_a = 4'd12; fixed_a = 32'h3F80_0000; mode_b = 4'd0;
        num_vectors = 16'd2; out_ready = 1'b0;
        pulse_start();
        wait_vld("t5_valid");
        fixed_a = 32'h4000_0000; num_vectors = 16'd5;
        pulse_start();
        chk("t5_busy_a_kept", a, 32'h3F80_0000);
        chk("t5_busy_b_zero", b, 32'h0);
        chk("t5_busy_idx", {16'b0, vec_idx}, 32'd0);
        out_ready = 1'b1;
        nvec = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) break;
            if (out_valid === 1'b1) nvec++;
            tick();
        end
        chk("t5_run_len", nvec, 32'd2);
        chk("t5_run_done", {31'b0, done}, 32'd1);
        chk("t5_last_a", a, 32'h3F80_0000);
        tick();

        // ---- test 6: reset mid-run, then a fresh seeded run ----
        do_reset();
        mode_a = 4'd1; mode_b = 4'd1; op_mode = 2'd2; order = 2'd0;
        num_vectors = 16'd4; out_ready = 1'b1;
        pulse_start();
        wait_vld("t6_pre_valid0");
        tick();
        out_ready = 1'b0;
        wait_vld("t6_pre_valid1");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_a", a, 32'h0);
        chk("t6_rst_b", b, 32'h0);
        chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_rst_idx", {16'b0, vec_idx}, 32'd0);
        chk("t6_rst_busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_rst_no_done", {31'b0, done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_post_rst_no_done", {31'b0, done}, 32'd0);
        out_ready = 1'b1;
        pulse_start();
        m = 32'h1;
        for (int i = 0; i < 4; i++) begin
            r1 = nxt(m);
            r2 = nxt(r1);
            m  = r2;
            wait_vld("t6_valid");
            chk("t6_a", a, r1);
            chk("t6_b", b, r2);
            chk("t6_op", {31'b0, operation_select}, {31'b0, r1[0] ^ r2[31]});
            chk("t6_vec_idx", {16'b0, vec_idx}, i);
            tick();
        end
        chk("t6_done", {31'b0, done}, 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_stim_gen.md
Name: fp_stim_gen

Overview:
- Synthesizable, parametrised floating-point operand sequencer for the FP add/sub datapath.
- Emits a programmed number of (a, b, operation_select) vectors over a valid/ready handshake.
- Operand classes are selectable per operand: zero, LFSR random, NaN, ±inf, max/min normal, min denormal, small-range custom, or a fixed value.
- Drives the DUT in emulation/FPGA regressions, where no simulator-side stimulus is available; supports arbitrary IEEE-style widths.

Parameters:
- WIDTH, 32, total operand width.
- EXP_BITS, 8, exponent field width; must be at least 3.
- MANT_BITS, 23, mantissa field width; WIDTH = 1 + EXP_BITS + MANT_BITS; must be at least 3.
- CNT_W, 16, width of the vector counter.
- LFSR_TAPS, 32'h8020_0003, WIDTH-bit Galois tap mask.
- SEED, 32'h0000_0001, WIDTH-bit LFSR reset value; a value of 0 is replaced by 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  one-cycle request to begin a run; ignored while busy=1.
- mode_a  in  4  operand class for a; latched when start is accepted.
- mode_b  in  4  operand class for b; latched when start is accepted.
- op_mode  in  2  0=add, 1=sub, 2/3=random; latched when start is accepted.
- order  in  2  0=none, 1=force a>=b, 2=force a<=b (unsigned compare), 3=none; latched when start is accepted.
- num_vectors  in  CNT_W  number of vectors in the run; latched when start is accepted.
- fixed_a  in  WIDTH  value used for a in FIXED mode; latched when start is accepted.
- fixed_b  in  WIDTH  value used for b in FIXED mode; latched when start is accepted.
- a  out  WIDTH  operand A.
- b  out  WIDTH  operand B.
- operation_select  out  1  0=add, 1=sub.
- out_valid  out  1  vector on a/b/operation_select is valid.
- out_ready  in  1  consumer accepts the vector.
- vec_idx  out  CNT_W  index of the vector currently presented.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, rst_n=0):
  - a=0, b=0, operation_select=0, out_valid=0, vec_idx=0, busy=0, done=0.
  - lfsr=SEED (1 if SEED=0); FSM=IDLE.
  - Reset mid-run aborts immediately; no done pulse is issued.
- LFSR step, nxt(s) = (s>>1) ^ (s[0] ? LFSR_TAPS : 0).
- In each GEN cycle: r1=nxt(lfsr), r2=nxt(r1), then lfsr<=r2. The LFSR advances every GEN regardless of mode.
- Operand a uses r1; operand b uses r2.
- Mode encoding (E = all-ones exponent):
  - 0 ZERO = 0.
  - 1 RANDOM = r.
  - 2 QNAN = {0, E, 1, 0...}.
  - 3 POS_INF = {0, E, 0}.
  - 4 NEG_INF = {1, E, 0}.
  - 5 MAX_POS = {0, E-1, all ones}.
  - 6 MAX_NEG = {1, E-1, all ones}.
  - 7 MIN_POS = {0, 1, 0}.
  - 8 MIN_NEG = {1, 1, 0}.
  - 9 MIN_POS_DENORM = {0, 0, 1}.
  - 10 MIN_NEG_DENORM = {1, 0, 1}.
  - 11 CUSTOM = {0, {1'b1, zeros, r[1:0]}, {r[4:2], zeros}}.
  - 12 FIXED = fixed_a or fixed_b.
  - 13..15 behave as ZERO.
- All constants are derived from EXP_BITS/MANT_BITS, not hard-coded.
- operation_select: 0 for op_mode 0, 1 for op_mode 1, and r1[0]^r2[WIDTH-1] for op_mode 2/3.
- Ordering: after class selection, swap a and b if order=1 and a<b, or if order=2 and a>b. Equal values are left unchanged.
- FSM states:
  - IDLE: start=1 and num_vectors>0 → latch config, busy<=1, vec_idx<=0, go to GEN. start=1 and num_vectors=0 → DONE, no vectors emitted.
  - GEN: compute and register a, b, operation_select; out_valid<=1; go to PRESENT.
  - PRESENT: a, b, operation_select and vec_idx are held stable while out_valid=1 and out_ready=0. On out_valid&out_ready, out_valid<=0.
    - If vec_idx==num_vectors-1 → DONE.
    - Else vec_idx<=vec_idx+1 → GEN.
  - DONE: done=1 for one cycle, busy<=0 → IDLE.
- Timing:
  - Latency from start edge to out_valid=1 is 2 cycles.
  - Maximum throughput is one vector per 2 cycles.
  - out_valid never drops without a handshake.
- Outputs a/b keep the last vector after the run completes.
- num_vectors = 2^CNT_W-1 is supported; vec_idx never wraps within a run.
- The LFSR state persists across runs; it is re-seeded only by reset.

Test Plan:
1. Reset, SEED=1, mode_a=mode_b=RANDOM, op_mode=0, num_vectors=1, out_ready=1 → a=32'h8020_0003, b=32'hC030_0002, operation_select=0, out_valid at start+2, done one cycle after handshake.
2. mode_a=QNAN, mode_b=NEG_INF, op_mode=1, num_vectors=3 → three vectors a=32'h7FC0_0000, b=32'hFF80_0000, operation_select=1, vec_idx 0,1,2, single done pulse.
3. Same as test 1 with order=2 → a=32'h8020_0003, b=32'hC030_0002 (no swap). With order=1 → a=32'hC030_0002, b=32'h8020_0003.
4. After reset, mode_a=CUSTOM, mode_b=MIN_POS_DENORM → a=32'h4180_0000, b=32'h0000_0001. out_ready held low 5 cycles → outputs stable, out_valid stays high, vec_idx=0.
5. num_vectors=0 with start → no out_valid, done pulse next cycle; start pulses while busy=1 → ignored, run length unchanged.
6. rst_n asserted in PRESENT with num_vectors=4 → all outputs 0 immediately, no done pulse. Restart → a run of 4 vectors resumes from the SEED sequence.
